// File: rtl/sseg_scan_driver.sv
// Multiplexed N-digit seven-segment scan driver, common-anode, active-low pins.
// Ports: clk, rst (sync, active-low), value/dp_in/load shadow capture,
//   hex_mode, blank_lz controls; seg/dp/an registered pins, digit_idx scan index.
module sseg_scan_driver #(
  parameter  int NUM_DIGITS   = 4,
  parameter  int REFRESH_DIV  = 50000,
  parameter  int BLANK_CYCLES = 16,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    hex_mode,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [4*NUM_DIGITS-1:0] val_q, val_d;
  logic [NUM_DIGITS-1:0]   dps_q, dps_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic [3:0]            nib;
  logic                  cur_dp;
  logic                  cur_hz;
  logic                  run_zero;
  logic [NUM_DIGITS-1:0] hi_zero;
  logic                  blank_dig;
  logic                  in_blank;

  // Active-high gfedcba pattern.
  function automatic logic [6:0] decode(
    input logic [3:0] n,
    input logic       hex
  );
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      default: p = 7'h71;
    endcase
    if (!hex && (n > 4'h9)) p = 7'h40;
    return p;
  endfunction

  // Shadow capture and refresh counter / scan index.
  always_comb begin
    val_d = load ? value : val_q;
    dps_d = load ? dp_in : dps_q;
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      if (idx_q == IDX_W'(NUM_DIGITS - 1)) idx_d = '0;
      else                                 idx_d = idx_q + IDX_W'(1);
    end
  end

  // hi_zero[i]: nibbles i..top of the shadow value are all zero.
  always_comb begin
    run_zero = 1'b1;
    hi_zero  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_zero   = run_zero & (val_q[4*i +: 4] == 4'h0);
      hi_zero[i] = run_zero;
    end
  end

  // Select the nibble and attributes of the digit in its slot.
  always_comb begin
    nib    = '0;
    cur_dp = 1'b0;
    cur_hz = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib    = val_q[4*i +: 4];
        cur_dp = dps_q[i];
        cur_hz = hi_zero[i];
      end
    end
  end

  // Next pin values, one cycle behind the scan state.
  always_comb begin
    in_blank  = ({1'b0, cnt_q} < (CNT_W + 1)'(BLANK_CYCLES));
    blank_dig = blank_lz && (idx_q != '0) && cur_hz;
    an_d      = ~(NUM_DIGITS'(1) << idx_q);
    seg_d     = blank_dig ? 7'h7F : ~decode(nib, hex_mode);
    dp_d      = ~cur_dp;
    if (in_blank) begin
      an_d  = '1;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      val_q <= '0;
      dps_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
      an_q  <= '1;
    end else begin
      val_q <= val_d;
      dps_q <= dps_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign seg       = seg_q;
  assign dp        = dp_q;
  assign an        = an_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver (4 digits, REFRESH_DIV=4, BLANK_CYCLES=1).
// Table-driven scan sequence plus hand-written corner sequences.
module tb_sseg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_in;
  logic        hex_mode;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  digit_idx;

  int errors = 0;
  int checks = 0;
  int tcount = 0;

  sseg_scan_driver #(
    .NUM_DIGITS(4),
    .REFRESH_DIV(4),
    .BLANK_CYCLES(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .value(value),
    .load(load),
    .dp_in(dp_in),
    .hex_mode(hex_mode),
    .blank_lz(blank_lz),
    .seg(seg),
    .dp(dp),
    .an(an),
    .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  idx;
  } vec_t;

  vec_t vt[21];

  function automatic vec_t mk(
    input logic r, input logic l, input logic [15:0] v, input logic [3:0] d,
    input logic [3:0] a, input logic [6:0] s, input logic p, input logic [1:0] x
  );
    vec_t e;
    e.rst = r; e.load = l; e.value = v; e.dp_in = d;
    e.an = a; e.seg = s; e.dp = p; e.idx = x;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    tcount++;
  endtask

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic restart(input logic [15:0] v, input logic [3:0] d);
    rst = 1'b0;
    load = 1'b0;
    tick();
    rst = 1'b1;
    load = 1'b1;
    value = v;
    dp_in = d;
    tcount = 0;
    tick();
    load = 1'b0;
  endtask

  task automatic goto(input int t);
    while (tcount < t) tick();
  endtask

  task automatic dig(input string name, input int t, input logic [3:0] a,
                     input logic [6:0] s, input logic p);
    goto(t);
    chk({name, ".an"}, {4'h0, an}, {4'h0, a});
    chk({name, ".seg"}, {1'b0, seg}, {1'b0, s});
    chk({name, ".dp"}, {7'h0, dp}, {7'h0, p});
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; value = 16'h1234; dp_in = 4'b0;
    hex_mode = 1'b1; blank_lz = 1'b0;

    for (int i = 0; i < 3; i++)
      vt[i] = mk(1'b0, 1'b0, 16'h1234, 4'b0, 4'hF, 7'h7F, 1'b1, 2'd0);
    vt[3]  = mk(1'b1, 1'b1, 16'h1234, 4'b0100, 4'hF, 7'h7F, 1'b1, 2'd0);
    vt[4]  = mk(1'b1, 1'b0, 16'h1234, 4'b0100, 4'hE, 7'h19, 1'b1, 2'd0);
    vt[5]  = mk(1'b1, 1'b0, 16'h1234, 4'b0100, 4'hE, 7'h19, 1'b1, 2'd0);
    vt[6]  = mk(1'b1, 1'b0, 16'h1234, 4'b0100, 4'hE, 7'h19, 1'b1, 2'd1);
    vt[7]  = mk(1'b1, 1'b0, 16'h1234, 4'b0100, 4'hF, 7'h7F, 1'b1, 2'd1);
    vt[8]  = mk(1'b1, 1'b0, 16'h1234, 4'b0100, 4'hD, 7'h30, 1'b1, 2'd1);
    vt[9]  = mk(1'b1, 1'b0, 16'h1234, 4'b0100, 4'hD, 7'h30, 1'b1, 2'd1);
    vt[10] = mk(1'b1, 1'b0, 16'h1234, 4'b0100, 4'hD, 7'h30, 1'b1, 2'd2);
    vt[11] = mk(1'b1, 1'b0, 16'h1234, 4'b0100, 4'hF, 7'h7F, 1'b1, 2'd2);
    vt[12] = mk(1'b1, 1'b0, 16'h1234, 4'b0100, 4'hB, 7'h24, 1'b0, 2'd2);
    vt[13] = mk(1'b1, 1'b0, 16'h1234, 4'b0100, 4'hB, 7'h24, 1'b0, 2'd2);
    vt[14] = mk(1'b1, 1'b0, 16'h1234, 4'b0100, 4'hB, 7'h24, 1'b0, 2'd3);
    vt[15] = mk(1'b1, 1'b0, 16'h1234, 4'b0100, 4'hF, 7'h7F, 1'b1, 2'd3);
    vt[16] = mk(1'b1, 1'b0, 16'h1234, 4'b0100, 4'h7, 7'h79, 1'b1, 2'd3);
    vt[17] = mk(1'b1, 1'b0, 16'h1234, 4'b0100, 4'h7, 7'h79, 1'b1, 2'd3);
    vt[18] = mk(1'b1, 1'b0, 16'h1234, 4'b0100, 4'h7, 7'h79, 1'b1, 2'd0);
    vt[19] = mk(1'b1, 1'b0, 16'h1234, 4'b0100, 4'hF, 7'h7F, 1'b1, 2'd0);
    vt[20] = mk(1'b1, 1'b0, 16'h1234, 4'b0100, 4'hE, 7'h19, 1'b1, 2'd0);

    // Reset and scan order
    for (int i = 0; i < 21; i++) begin
      rst = vt[i].rst; load = vt[i].load;
      value = vt[i].value; dp_in = vt[i].dp_in;
      tick();
      chk($sformatf("scan%0d.an", i), {4'h0, an}, {4'h0, vt[i].an});
      chk($sformatf("scan%0d.seg", i), {1'b0, seg}, {1'b0, vt[i].seg});
      chk($sformatf("scan%0d.dp", i), {7'h0, dp}, {7'h0, vt[i].dp});
      chk($sformatf("scan%0d.idx", i), {6'h0, digit_idx},
          {6'h0, vt[i].idx});
    end

    // Hex vs decimal; hex_mode is live, not shadowed
    hex_mode = 1'b1;
    restart(16'hAF09, 4'b0);
    dig("hex.d0", 3, 4'hE, 7'h10, 1'b1);
    dig("hex.d1", 7, 4'hD, 7'h40, 1'b1);
    dig("hex.d2", 11, 4'hB, 7'h0E, 1'b1);
    dig("hex.d3", 15, 4'h7, 7'h08, 1'b1);
    goto(17);
    hex_mode = 1'b0;
    dig("dec.d0", 19, 4'hE, 7'h10, 1'b1);
    dig("dec.d1", 23, 4'hD, 7'h40, 1'b1);
    dig("dec.d2", 27, 4'hB, 7'h3F, 1'b1);
    dig("dec.d3", 31, 4'h7, 7'h3F, 1'b1);
    hex_mode = 1'b1;

    // Leading-zero blanking
    blank_lz = 1'b1;
    restart(16'h0070, 4'b0);
    dig("lz70.d0", 3, 4'hE, 7'h40, 1'b1);
    dig("lz70.d1", 7, 4'hD, 7'h78, 1'b1);
    dig("lz70.d2", 11, 4'hB, 7'h7F, 1'b1);
    dig("lz70.d3", 15, 4'h7, 7'h7F, 1'b1);
    restart(16'h0000, 4'b1000);
    dig("lz00.d0", 3, 4'hE, 7'h40, 1'b1);
    dig("lz00.d1", 7, 4'hD, 7'h7F, 1'b1);
    dig("lz00.d3", 15, 4'h7, 7'h7F, 1'b0);
    blank_lz = 1'b0;

    // Load coinciding with slot change
    restart(16'h1234, 4'b0);
    goto(3);
    load = 1'b1;
    value = 16'h5555;
    tick();
    load = 1'b0;
    chk("bnd.idx", {6'h0, digit_idx}, 8'd1);
    chk("bnd.old_seg", {1'b0, seg}, 8'h19);
    dig("bnd.dark", 5, 4'hF, 7'h7F, 1'b1);
    dig("bnd.new", 6, 4'hD, 7'h12, 1'b1);
    goto(8);
    chk("bnd.idx2", {6'h0, digit_idx}, 8'd2);

    // Reset mid-scan
    restart(16'h1234, 4'b0);
    goto(10);
    chk("mid.pre_idx", {6'h0, digit_idx}, 8'd2);
    rst = 1'b0;
    tick();
    chk("mid.idx", {6'h0, digit_idx}, 8'd0);
    chk("mid.an", {4'h0, an}, 8'h0F);
    chk("mid.seg", {1'b0, seg}, 8'h7F);
    rst = 1'b1;
    tick();
    chk("mid.rel_an", {4'h0, an}, 8'h0F);
    tick();
    chk("mid.first_an", {4'h0, an}, 8'h0E);
    chk("mid.first_seg", {1'b0, seg}, 8'h40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
- Parametrised successor to the single-digit BCD/hex-to-seven-segment decoder.
- Drives an N-digit multiplexed common-anode display from one packed nibble vector.
- Adds:
  - a refresh counter and digit scanning;
  - an anti-ghosting blank window at each digit change;
  - a hex/decimal mode;
  - leading-zero blanking and per-digit decimal points.
- Sits between the datapath result registers and the board display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
REFRESH_DIV, 50000, clock cycles each digit stays selected (>= 2)
BLANK_CYCLES, 16, cycles at start of each digit slot with all anodes off (0..REFRESH_DIV-1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low
value  input  4*NUM_DIGITS  packed nibbles; nibble 0 (bits 3:0) = rightmost digit
load  input  1  capture value and dp_in into shadow registers on this edge
dp_in  input  NUM_DIGITS  decimal-point request per digit, 1 = lit
hex_mode  input  1  1: nibbles A-F shown as A b C d E F; 0: nibbles >9 shown as dash
blank_lz  input  1  1: enable leading-zero blanking
seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal-point cathode, active-low
an  output  NUM_DIGITS  anodes, active-low, one-hot-low when a digit is lit
digit_idx  output  clog2(NUM_DIGITS) (min 1)  index of digit currently in its slot

Behaviour:
- All state updates on the rising edge of clk.
- rst is sampled on the clock edge; rst=0 forces:
  - shadow value = 0, shadow dp = 0;
  - refresh counter cnt = 0, digit_idx = 0;
  - seg = 7'h7F, dp = 1, an = all ones (display dark).
- Reset mid-scan aborts the current slot. The first slot after reset release is digit 0.
- Shadow registers:
  - load=1 captures value and dp_in.
  - load=0 holds the previous contents.
  - Scan position is never altered by load.
- Refresh counter:
  - cnt increments every cycle.
  - When cnt == REFRESH_DIV-1: cnt returns to 0 and digit_idx advances.
  - digit_idx wraps from NUM_DIGITS-1 to 0.
  - NUM_DIGITS=1: digit_idx stays 0 and only the blank window repeats.
- Output stage:
  - seg, dp and an are registered and computed from the current cycle's cnt, digit_idx and shadow registers.
  - Pin outputs therefore lag the digit_idx/cnt state by exactly 1 cycle.
  - digit_idx itself is the state register, with no extra lag.
- Blank window:
  - While cnt < BLANK_CYCLES, next an = all ones, seg = 7'h7F, dp = 1.
  - Otherwise an has a single 0 at bit digit_idx.
- Digit blanking:
  - Digit i > 0 is blanked when blank_lz=1 and nibbles i..NUM_DIGITS-1 of the shadow value are all zero.
  - Digit 0 is never blanked.
  - A blanked digit drives seg = 7'h7F but keeps its anode active and still shows its dp.
- Decode:
  - Active-high gfedcba pattern, then inverted onto seg.
  - Patterns:
    - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F
    - A=77, b=7C, C=39, d=5E, E=79, F=71
    - dash=40
  - Example: nibble 0 gives seg=7'h40; nibble 8 gives seg=7'h00.
- dp = ~shadow_dp[digit_idx] outside the blank window.
- Simultaneous load and slot change: both take effect. The new slot's first lit output uses the newly loaded data.
- hex_mode and blank_lz are not shadowed; a change affects the next registered output.

Test Plan:
(Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.)
1. Reset:
   - Stimulus: hold rst=0 for 3 cycles with value=16'h1234.
   - Response: an=4'hF, seg=7'h7F, dp=1, digit_idx=0 throughout.
2. Scan order:
   - Stimulus: release rst, pulse load with value=16'h1234, dp_in=4'b0100.
   - Response: an cycles 1110, 1101, 1011, 0111, each lit 3 cycles after one dark cycle.
   - seg pattern: 7'h19 (4), 7'h30 (3), 7'h24 (2), 7'h79 (1).
   - dp=0 only while an=1011.
   - The sequence wraps back to 1110.
3. Hex vs decimal:
   - Stimulus: value=16'hAF09 with hex_mode=1, then hex_mode=0.
   - Response (digits 3 and 2): hex_mode=1 shows 7'h08 (A) and 7'h0E (F); hex_mode=0 shows 7'h3F (dash) for both.
   - Response (digits 1 and 0): 7'h40 (0) and 7'h10 (9) in both modes.
4. Leading-zero blanking:
   - Stimulus: value=16'h0070, blank_lz=1.
   - Response: digits 3 and 2 drive seg=7'h7F with their anodes still active; digit 1 shows 7'h78 (7); digit 0 shows 7'h40 (0).
   - Stimulus: value=16'h0000.
   - Response: only digit 0 lit, showing 7'h40.
5. Load at slot boundary:
   - Stimulus: assert load with value=16'h5555 on the cycle cnt==3.
   - Response: the next lit cycle shows 7'h12 (5).
   - Response: no scan discontinuity; digit_idx advances normally.
6. Reset mid-scan:
   - Stimulus: drive rst=0 while digit_idx=2 and cnt=2.
   - Response: next edge gives digit_idx=0 and an=4'hF.
   - Response: after release, the first lit anode is 1110.
